// File: rtl/varredura_display.sv
// Multiplexed 7-segment scanner: blanking gap before every digit slot,
// double-buffered data swapped only at frame boundaries, optional leading-zero blanking.
module varredura_display #(
    parameter int N_DIG = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*N_DIG-1:0]   dados,
    input  logic                 carga,
    input  logic                 apaga_zeros,
    output logic                 pronto,
    output logic [6:0]           segmentos,
    output logic [N_DIG-1:0]     anodo,
    output logic                 fim_quadro
);

    localparam int CW = $clog2(DIV > BLANK ? DIV : BLANK);
    localparam int IW = $clog2(N_DIG);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);

    typedef enum logic {APAGADO, ATIVO} estado_t;

    estado_t              state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*N_DIG-1:0]   ativo_q, ativo_d;
    logic [4*N_DIG-1:0]   sombra_q, sombra_d;
    logic                 pend_q, pend_d;
    logic                 pronto_q, pronto_d;
    logic                 fim_q, fim_d;
    logic [6:0]           seg_q, seg_d;
    logic [N_DIG-1:0]     anodo_q, anodo_d;
    logic [N_DIG-1:0]     lz;
    logic [3:0]           digito;

    function automatic logic [6:0] decodifica(input logic [3:0] v);
        case (v)
            4'd0:    decodifica = 7'b0000001;
            4'd1:    decodifica = 7'b1001111;
            4'd2:    decodifica = 7'b0010010;
            4'd3:    decodifica = 7'b0000110;
            4'd4:    decodifica = 7'b1001100;
            4'd5:    decodifica = 7'b0100100;
            4'd6:    decodifica = 7'b0100000;
            4'd7:    decodifica = 7'b0001111;
            4'd8:    decodifica = 7'b0000000;
            4'd9:    decodifica = 7'b0001100;
            default: decodifica = 7'b1111110;
        endcase
    endfunction

    // lz[k] = 1 when digit k and every digit above it are zero
    function automatic logic [N_DIG-1:0] zeros_lideres(input logic [4*N_DIG-1:0] d);
        logic run;
        zeros_lideres = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            run = run & (d[4*(N_DIG-1-i) +: 4] == 4'd0);
            zeros_lideres[N_DIG-1-i] = run;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        fim_d    = 1'b0;
        ativo_d  = ativo_q;
        sombra_d = sombra_q;
        pend_d   = pend_q;

        case (state_q)
            APAGADO: if (cnt_q == BLANK_LAST) begin
                state_d = ATIVO;
                cnt_d   = '0;
            end
            ATIVO: if (cnt_q == DIV_LAST) begin
                state_d = APAGADO;
                cnt_d   = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                fim_d   = (idx_q == IDX_LAST);
            end
            default: state_d = APAGADO;
        endcase

        // fim_d marks the boundary cycle; a load there with nothing pending bypasses the shadow
        if (fim_d && pend_q) begin
            ativo_d = sombra_q;
            pend_d  = 1'b0;
        end
        if (carga && pronto_q) begin
            if (fim_d) begin
                ativo_d = dados;
            end else begin
                sombra_d = dados;
                pend_d   = 1'b1;
            end
        end
        pronto_d = !pend_d;

        // Outputs are registered from next-state values so they track state_q exactly
        lz      = zeros_lideres(ativo_d);
        digito  = ativo_d[4*idx_d +: 4];
        anodo_d = '1;
        seg_d   = '1;
        if (state_d == ATIVO) begin
            anodo_d[idx_d] = 1'b0;
            if (!(apaga_zeros && idx_d != '0 && lz[idx_d]))
                seg_d = decodifica(digito);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= APAGADO;
            cnt_q    <= '0;
            idx_q    <= '0;
            ativo_q  <= '0;
            sombra_q <= '0;
            pend_q   <= 1'b0;
            pronto_q <= 1'b1;
            fim_q    <= 1'b0;
            seg_q    <= '1;
            anodo_q  <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ativo_q  <= ativo_d;
            sombra_q <= sombra_d;
            pend_q   <= pend_d;
            pronto_q <= pronto_d;
            fim_q    <= fim_d;
            seg_q    <= seg_d;
            anodo_q  <= anodo_d;
        end
    end

    assign pronto     = pronto_q;
    assign segmentos  = seg_q;
    assign anodo      = anodo_q;
    assign fim_quadro = fim_q;

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display with N_DIG=4, DIV=4, BLANK=2 (24-cycle frame).
module tb_varredura_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dados;
    logic        carga;
    logic        apaga_zeros;
    logic        pronto;
    logic [6:0]  segmentos;
    logic [3:0]  anodo;
    logic        fim_quadro;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S7 = 7'b0001111,
                           S9 = 7'b0001100, SD = 7'b1111110, SB = 7'b1111111;

    varredura_display #(.N_DIG(4), .DIV(4), .BLANK(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dados       (dados),
        .carga       (carga),
        .apaga_zeros (apaga_zeros),
        .pronto      (pronto),
        .segmentos   (segmentos),
        .anodo       (anodo),
        .fim_quadro  (fim_quadro)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_fim(input string tag);
        int n = 0;
        tick(1);
        while (fim_quadro !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        chk(tag, {15'd0, fim_quadro}, 16'd1);
    endtask

    // Starts at the cycle right after a frame boundary (minus 'off' cycles already spent)
    task automatic check_frame(input string tag, input int off,
                               input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        tick(2 - off);
        chk({tag, "_an0"}, {12'd0, anodo}, 16'b1110);
        chk({tag, "_d0"},  {9'd0, segmentos}, {9'd0, e0});
        tick(6);
        chk({tag, "_an1"}, {12'd0, anodo}, 16'b1101);
        chk({tag, "_d1"},  {9'd0, segmentos}, {9'd0, e1});
        tick(6);
        chk({tag, "_an2"}, {12'd0, anodo}, 16'b1011);
        chk({tag, "_d2"},  {9'd0, segmentos}, {9'd0, e2});
        tick(6);
        chk({tag, "_an3"}, {12'd0, anodo}, 16'b0111);
        chk({tag, "_d3"},  {9'd0, segmentos}, {9'd0, e3});
        tick(4);
        chk({tag, "_fim"}, {15'd0, fim_quadro}, 16'd1);
    endtask

    initial begin
        rst_n = 1'b0; dados = '0; carga = 1'b0; apaga_zeros = 1'b0;
        tick(3);
        chk("rst_anodo",  {12'd0, anodo}, 16'hF);
        chk("rst_seg",    {9'd0, segmentos}, {9'd0, SB});
        chk("rst_pronto", {15'd0, pronto}, 16'd1);
        chk("rst_fim",    {15'd0, fim_quadro}, 16'd0);

        rst_n = 1'b1;
        chk("blank0", {12'd0, anodo}, 16'hF);
        tick(1);
        chk("blank1", {12'd0, anodo}, 16'hF);
        tick(1);
        chk("first_an", {12'd0, anodo}, 16'b1110);
        chk("first_seg", {9'd0, segmentos}, {9'd0, S0});
        tick(3);
        chk("first_an_last", {12'd0, anodo}, 16'b1110);
        tick(1);
        chk("gap_after_d0", {12'd0, anodo}, 16'hF);
        tick(18);
        chk("fim_24", {15'd0, fim_quadro}, 16'd1);
        tick(1);
        chk("fim_one_cycle", {15'd0, fim_quadro}, 16'd0);
        tick(23);
        chk("fim_48", {15'd0, fim_quadro}, 16'd1);
        chk("pronto_idle", {15'd0, pronto}, 16'd1);

        // Mid-frame load, then an ignored second load
        tick(2);
        dados = 16'h1234; carga = 1'b1;
        tick(1);
        carga = 1'b0;
        chk("load_pronto0", {15'd0, pronto}, 16'd0);
        chk("no_midframe_change", {9'd0, segmentos}, {9'd0, S0});
        dados = 16'h5678; carga = 1'b1;
        tick(1);
        carga = 1'b0;
        chk("ignored_pronto0", {15'd0, pronto}, 16'd0);
        wait_fim("wait_b1");
        chk("pronto_after_b", {15'd0, pronto}, 16'd1);
        check_frame("f1234", 0, S4, S3, S2, S1);

        // Leading-zero blanking
        apaga_zeros = 1'b1;
        dados = 16'h0070; carga = 1'b1;
        tick(1);
        carga = 1'b0;
        chk("load70_pronto0", {15'd0, pronto}, 16'd0);
        check_frame("keep1234", 1, S4, S3, S2, S1);
        check_frame("f0070", 0, S0, S7, SB, SB);
        chk("pronto_70", {15'd0, pronto}, 16'd1);
        dados = 16'h0000; carga = 1'b1;
        tick(1);
        carga = 1'b0;
        check_frame("keep0070", 1, S0, S7, SB, SB);
        check_frame("f0000", 0, S0, SB, SB, SB);

        // Non-BCD nibbles
        dados = 16'hA0F9; carga = 1'b1;
        tick(1);
        carga = 1'b0;
        check_frame("keep0000", 1, S0, SB, SB, SB);
        check_frame("fA0F9", 0, S9, SD, S0, SD);

        // Load on the boundary cycle itself
        tick(23);
        chk("pre_b_pronto", {15'd0, pronto}, 16'd1);
        dados = 16'h1234; carga = 1'b1;
        tick(1);
        carga = 1'b0;
        chk("b_load_fim", {15'd0, fim_quadro}, 16'd1);
        chk("b_load_pronto", {15'd0, pronto}, 16'd1);
        check_frame("fb1234", 0, S4, S3, S2, S1);
        chk("b_load_pronto_end", {15'd0, pronto}, 16'd1);

        // Asynchronous reset mid-ATIVO with a pending load
        dados = 16'h5678; carga = 1'b1;
        tick(1);
        carga = 1'b0;
        chk("pend_pronto0", {15'd0, pronto}, 16'd0);
        tick(1);
        chk("pre_rst_an", {12'd0, anodo}, 16'b1110);
        chk("pre_rst_seg", {9'd0, segmentos}, {9'd0, S4});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_anodo",  {12'd0, anodo}, 16'hF);
        chk("arst_seg",    {9'd0, segmentos}, {9'd0, SB});
        chk("arst_pronto", {15'd0, pronto}, 16'd1);
        chk("arst_fim",    {15'd0, fim_quadro}, 16'd0);
        tick(2);
        rst_n = 1'b1;
        chk("rel_blank0", {12'd0, anodo}, 16'hF);
        tick(1);
        chk("rel_blank1", {12'd0, anodo}, 16'hF);
        tick(1);
        chk("rel_an", {12'd0, anodo}, 16'b1110);
        chk("rel_seg", {9'd0, segmentos}, {9'd0, S0});
        wait_fim("wait_rel");
        chk("rel_pronto", {15'd0, pronto}, 16'd1);
        check_frame("dropped", 0, S0, SB, SB, SB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/varredura_display.md
VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 The block SHALL have parameter N_DIG, default 4, giving the number of multiplexed 7-segment digits (legal range 2..8).
REQ-002 The block SHALL have parameter DIV, default 50000, giving the clock cycles each digit is lit per slot (minimum 2).
REQ-003 The block SHALL have parameter BLANK, default 16, giving the clock cycles all digits are dark before each slot (minimum 1).
REQ-004 One clock and an asynchronous, active-low reset SHALL be used, as the ports clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 dados  input  4*N_DIG  BCD digits; dados[3:0] is digit 0, the least significant.
REQ-008 carga  input  1  load strobe; sampled only when pronto=1.
REQ-009 apaga_zeros  input  1  level; 1 enables leading-zero blanking.
REQ-010 pronto  output  1  1 = shadow register free, load accepted.
REQ-011 segmentos  output  7  active-low segments; segmentos[6]=a ... segmentos[0]=g.
REQ-012 anodo  output  N_DIG  active-low digit enables; anodo[k] drives digit k.
REQ-013 fim_quadro  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-014 All outputs SHALL be registered; no combinational path SHALL run from any input to any output.
REQ-015 The FSM SHALL have two states: APAGADO (all anodo=1, segmentos=7'b1111111, BLANK cycles) and ATIVO (one anodo bit low, DIV cycles).
REQ-016 A cycle counter SHALL count 0..BLANK-1 in APAGADO and 0..DIV-1 in ATIVO, and SHALL reset to 0 on every state change.
REQ-017 APAGADO SHALL go to ATIVO after BLANK cycles; ATIVO SHALL go to APAGADO after DIV cycles, with the digit index idx advancing 0,1,...,N_DIG-1 and wrapping to 0.
REQ-018 In ATIVO, anodo SHALL be all ones except anodo[idx]=0, and segmentos SHALL be the decode of active digit idx.
REQ-019 Decode (segments a..g, 0 = lit) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
REQ-020 Nibble values 10..15 SHALL decode to 1111110, which lights segment g only (a dash).
REQ-021 With apaga_zeros=1, each zero digit above the highest nonzero digit SHALL show 1111111 while its anodo is still driven low; digit 0 SHALL never be blanked.
REQ-022 A load SHALL be accepted on a cycle with carga=1 and pronto=1: dados goes to the shadow register and pronto drops to 0 on the next cycle.
REQ-023 carga while pronto=0 SHALL be ignored, and the shadow register SHALL be kept unchanged.
REQ-024 The frame boundary SHALL be the last ATIVO cycle of idx=N_DIG-1: fim_quadro=1 on the following cycle only.
REQ-025 At the boundary, a pending shadow value SHALL move to the active register, and pronto SHALL return to 1 on the next cycle.
REQ-026 Simultaneous events: if a load is accepted on the boundary cycle with nothing pending, dados SHALL go directly to the active register and pronto SHALL stay 1.
REQ-027 Data change SHALL take effect only at frame boundaries; a frame SHALL never show digits from two different loads.
REQ-028 Frame length SHALL be exactly N_DIG*(BLANK+DIV) cycles.

Reset
REQ-029 While rst_n=0, the outputs SHALL be: anodo all ones, segmentos=1111111, pronto=1, fim_quadro=0.
REQ-030 While rst_n=0, the internal state SHALL be: state APAGADO, counter 0, idx 0, active and shadow registers 0, no load pending.
REQ-031 Reset asserted mid-frame SHALL take effect immediately (asynchronously) and drop any pending load.
REQ-032 After rst_n rises, the first ATIVO SHALL begin BLANK cycles later with idx 0.

Verification (N_DIG=4, DIV=4, BLANK=2)
REQ-033 Reset release, carga=0 -> anodo=1111 for 2 cycles, then anodo=1110 with segmentos=0000001 for 4 cycles; fim_quadro pulses every 24 cycles.
REQ-034 Load dados=16'h1234 mid-frame -> pronto=0 until the boundary; next frame shows 4,3,2,1 on anodo[0..3]; pronto=1 after the boundary.
REQ-035 Second carga (dados=16'h5678) while pronto=0 -> ignored; display stays 1234.
REQ-036 apaga_zeros=1 with dados=16'h0070 -> digits 3 and 2 show 1111111, digit 1 shows 0001111, digit 0 shows 0000001; dados=16'h0000 -> only digit 0 shows 0000001.
REQ-037 dados=16'hA0F9 -> digits 3 and 1 show 1111110, digit 2 shows 0000001, digit 0 shows 0001100.
REQ-038 Load accepted on the boundary cycle with nothing pending -> new value shown from the next frame and pronto never drops; rst_n pulsed low mid-ATIVO -> all outputs reach reset values within the same cycle.
